// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_op_e    : operation encoding presented on the op port.
//   md_state_e : sequencing states of the unit's control FSM.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iteration datapath of the multiply/divide unit: one radix-2 step per cycle
// over a 2*WIDTH-bit accumulator, operating on unsigned magnitudes.
//   clk_i      : rising-edge clock
//   rst_ni     : asynchronous active-low reset
//   load_i     : initialise accumulator/operand and clear the counter
//   step_i     : perform one iteration and advance the counter
//   is_div_i   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_init_i : multiplier (multiply) or dividend (divide) magnitude
//   opnd_i     : multiplicand (multiply) or divisor (divide) magnitude
//   res_o      : accumulator; product, or {remainder, quotient}
//   last_o     : the step taken this cycle is the final one
module muldiv_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 is_div_i,
  input  logic [WIDTH-1:0]     acc_init_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   res_o,
  output logic                 last_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_diff;

  always_comb begin
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set; the carry becomes the new top bit.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    // Divide: acc holds {partial remainder, dividend/quotient}. Shifting left
    // pulls the next dividend bit into the remainder; the extra bit keeps the
    // trial subtraction exact.
    div_shift = {acc_q, 1'b0};
    div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, opnd_q};

    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;

    if (load_i) begin
      acc_d  = {{WIDTH{1'b0}}, acc_init_i};
      opnd_d = opnd_i;
      cnt_d  = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (is_div_i) begin
        // Negative trial difference: restore (keep the shifted remainder),
        // quotient bit 0. Otherwise accept the difference, quotient bit 1.
        if (div_diff[WIDTH]) begin
          acc_d = div_shift[2*WIDTH-1:0];
        end else begin
          acc_d = {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
        end
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign res_o  = acc_q;
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers, placed
// beside the execute-stage ALU.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   start   : operation request, sampled only while idle
//   op      : MULT/MULTU/DIV/DIVU/MTHI/MTLO (6,7 ignored)
//   srca    : rs operand (multiplicand / dividend / move source)
//   srcb    : rt operand (multiplier / divisor)
//   flush   : abort any in-flight operation, suppress a same-cycle start
//   hi, lo  : HI/LO registers
//   busy    : operation in flight (stall request)
//   done    : one-cycle pulse when HI/LO take a MULT/DIV result
//   divzero : with done, the completed divide had a zero divisor
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divzero
);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, divzero_q, divzero_d;

  // Operation context captured at start and used by the final fixup.
  logic             is_div_q, is_div_d;
  logic             neg_main_q, neg_main_d;   // product / quotient sign
  logic             neg_rem_q, neg_rem_d;     // remainder sign
  logic             bzero_q, bzero_d;         // divisor was zero
  logic [WIDTH-1:0] srca_q, srca_d;           // original dividend for /0

  md_op_e           op_e;
  logic             is_div_op, is_signed_op, sa, sb, load;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [2*WIDTH-1:0] core_res;
  logic               core_last;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign op_e         = md_op_e'(op);
  assign is_div_op    = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign is_signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign sa           = is_signed_op & srca[WIDTH-1];
  assign sb           = is_signed_op & srcb[WIDTH-1];
  assign a_mag        = sa ? neg_w(srca) : srca;
  assign b_mag        = sb ? neg_w(srcb) : srcb;

  muldiv_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (load),
    .step_i     (state_q == CALC),
    .is_div_i   (is_div_q),
    .acc_init_i (is_div_op ? a_mag : b_mag),
    .opnd_i     (is_div_op ? b_mag : a_mag),
    .res_o      (core_res),
    .last_o     (core_last)
  );

  // Sign fixup of the magnitude result. A zero divisor bypasses the
  // arithmetic: quotient all ones, remainder = the untouched dividend.
  always_comb begin
    prod_fix = neg_main_q ? neg_2w(core_res) : core_res;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (bzero_q) begin
        fix_hi = srca_q;
        fix_lo = '1;
      end else begin
        fix_hi = neg_rem_q  ? neg_w(core_res[2*WIDTH-1:WIDTH])
                            : core_res[2*WIDTH-1:WIDTH];
        fix_lo = neg_main_q ? neg_w(core_res[WIDTH-1:0])
                            : core_res[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // flush takes priority over any same-cycle request, moves included.
        if (start && !flush) begin
          case (op_e)
            MD_MTHI: hi_d = srca;
            MD_MTLO: lo_d = srca;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              load    = 1'b1;
              state_d = CALC;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (core_last) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d      = fix_hi;
          lo_d      = fix_lo;
          done_d    = 1'b1;
          divzero_d = is_div_q & bzero_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign is_div_d   = load ? is_div_op       : is_div_q;
  assign neg_main_d = load ? (sa ^ sb)       : neg_main_q;
  assign neg_rem_d  = load ? sa              : neg_rem_q;
  assign bzero_d    = load ? (srcb == '0)    : bzero_q;
  assign srca_d     = load ? srca            : srca_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      divzero_q  <= 1'b0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      bzero_q    <= 1'b0;
      srca_q     <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      divzero_q  <= divzero_d;
      is_div_q   <= is_div_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      bzero_q    <= bzero_d;
      srca_q     <= srca_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign divzero = divzero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int CYC_LIMIT = 60;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] srca, srcb;

  logic [31:0] hi32, lo32;
  logic        busy32, done32, dz32;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8, dz8;

  int nchk = 0;
  int nerr = 0;
  bit cmp_en = 0;

  // Transaction-level reference state, index 0 = 32-bit unit, 1 = 8-bit unit.
  int          m_left [2];
  logic [31:0] m_hi [2], m_lo [2], m_phi [2], m_plo [2];
  bit          m_done [2], m_dz [2], m_pdz [2];

  // Observations of the last directed operation.
  int lat32, lat8, dn32, dn8;
  bit dzs32, tmo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .divzero(dz32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca[7:0]), .srcb(srcb[7:0]),
    .flush(flush), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .divzero(dz8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Architectural result from plain integer arithmetic on a w-bit machine.
  function automatic void model_op(input int w, input logic [2:0] o,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl,
                                   output bit dz);
    logic [63:0] mask, ua, ub, t;
    longint      sa, sb, q, r, p;
    mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
    ua = {32'b0, a} & mask;
    ub = {32'b0, b} & mask;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    dz = 0;
    rh = '0;
    rl = '0;
    case (o)
      3'd0: begin
        p = sa * sb; t = p;
        rl = 32'(t & mask); rh = 32'((t >> w) & mask);
      end
      3'd1: begin
        t = ua * ub;
        rl = 32'(t & mask); rh = 32'((t >> w) & mask);
      end
      3'd2, 3'd3: begin
        if (ub == 0) begin
          dz = 1; rl = 32'(mask); rh = 32'(ua);
        end else begin
          if (o == 3'd2) begin q = sa / sb; r = sa % sb; end
          else begin q = longint'(ua / ub); r = longint'(ua % ub); end
          t = q; rl = 32'(t & mask);
          t = r; rh = 32'(t & mask);
        end
      end
      default: ;
    endcase
  endfunction

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; srca = a; srcb = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy/done cycles from the current negedge until both units idle.
  task automatic wait_idle();
    lat32 = 0; lat8 = 0; dn32 = 0; dn8 = 0; dzs32 = 0; tmo = 1;
    for (int c = 0; c < CYC_LIMIT; c++) begin
      if (busy32) lat32++;
      if (busy8) lat8++;
      if (done32) begin dn32++; if (dz32) dzs32 = 1; end
      if (done8) dn8++;
      if (c > 0 && !busy32 && !busy8) begin tmo = 0; break; end
      @(negedge clk);
    end
    if (tmo) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    launch(o, a, b);
    wait_idle();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      3: return {24'($urandom), 8'h80};
      4: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; srca = '0; srcb = '0;

    fork
      forever begin : model
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
          m_done[i] = 0;
          m_dz[i]   = 0;
          if (!reset) begin
            m_left[i] = 0; m_hi[i] = '0; m_lo[i] = '0;
          end else if (m_left[i] > 0) begin
            if (flush) m_left[i] = 0;
            else begin
              m_left[i]--;
              if (m_left[i] == 0) begin
                m_hi[i] = m_phi[i]; m_lo[i] = m_plo[i];
                m_done[i] = 1; m_dz[i] = m_pdz[i];
              end
            end
          end else if (start && !flush) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                model_op(i == 0 ? 32 : 8, op, srca, srcb, m_phi[i], m_plo[i], m_pdz[i]);
                m_left[i] = (i == 0 ? 32 : 8) + 1;
              end
              3'd4: m_hi[i] = (i == 0) ? srca : {24'b0, srca[7:0]};
              3'd5: m_lo[i] = (i == 0) ? srca : {24'b0, srca[7:0]};
              default: ;
            endcase
          end
        end
      end
      forever begin : compare
        @(negedge clk);
        if (reset && cmp_en) begin
          check("busy32", 64'(busy32), 64'(m_left[0] > 0));
          check("done32", 64'(done32), 64'(m_done[0]));
          check("divzero32", 64'(dz32), 64'(m_dz[0]));
          check("hi32", 64'(hi32), 64'(m_hi[0]));
          check("lo32", 64'(lo32), 64'(m_lo[0]));
          check("busy8", 64'(busy8), 64'(m_left[1] > 0));
          check("done8", 64'(done8), 64'(m_done[1]));
          check("divzero8", 64'(dz8), 64'(m_dz[1]));
          check("hi8", 64'(hi8), 64'(m_hi[1]));
          check("lo8", 64'(lo8), 64'(m_lo[1]));
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hi32", 64'(hi32), 64'd0);
    check("rst_lo32", 64'(lo32), 64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_dz32", 64'(dz32), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_hi8", 64'(hi8), 64'd0);
    reset = 1'b1;
    cmp_en = 1;

    // Moves to HI/LO
    @(negedge clk);
    op = 3'd4; srca = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);
    op = 3'd5; srca = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    check("mt_busy", 64'(busy32), 64'd0);
    check("mthi", 64'(hi32), 64'hDEAD_BEEF);
    check("mtlo", 64'(lo32), 64'h1234_5678);
    check("mthi8", 64'(hi8), 64'hEF);
    check("mtlo8", 64'(lo8), 64'h78);

    // Multiply
    run_op(3'd0, 32'hFFFF_FFFF, 32'h2);
    check("mult_hi", 64'(hi32), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo32), 64'hFFFF_FFFE);
    check("mult_lat32", 64'(lat32), 64'd33);
    check("mult_lat8", 64'(lat8), 64'd9);
    check("mult_done32", 64'(dn32), 64'd1);
    check("mult_done8", 64'(dn8), 64'd1);
    check("mult_hi8", 64'(hi8), 64'hFF);
    check("mult_lo8", 64'(lo8), 64'hFE);

    run_op(3'd1, 32'hFFFF_FFFF, 32'h2);
    check("multu_hi", 64'(hi32), 64'h1);
    check("multu_lo", 64'(lo32), 64'hFFFF_FFFE);
    check("multu_hi8", 64'(hi8), 64'h01);
    check("multu_lo8", 64'(lo8), 64'hFE);

    // Divide
    run_op(3'd2, 32'hFFFF_FFF9, 32'h2);
    check("div_lo", 64'(lo32), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi32), 64'hFFFF_FFFF);
    check("div_lo8", 64'(lo8), 64'hFD);
    check("div_hi8", 64'(hi8), 64'hFF);
    check("div_dz", 64'(dzs32), 64'd0);

    run_op(3'd3, 32'd100, 32'd7);
    check("divu_lo", 64'(lo32), 64'd14);
    check("divu_hi", 64'(hi32), 64'd2);
    check("divu_lo8", 64'(lo8), 64'd14);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_lo", 64'(lo32), 64'h8000_0000);
    check("divovf_hi", 64'(hi32), 64'h0);

    run_op(3'd3, 32'h55, 32'h0);
    check("dz_lo", 64'(lo32), 64'hFFFF_FFFF);
    check("dz_hi", 64'(hi32), 64'h55);
    check("dz_flag", 64'(dzs32), 64'd1);
    check("dz_lat32", 64'(lat32), 64'd33);

    // Flush on the 10th busy cycle of a MULT
    launch(3'd0, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy32), 64'd0);
    wait_idle();
    check("flush_done", 64'(dn32), 64'd0);
    check("flush_hi", 64'(hi32), 64'h55);
    check("flush_lo", 64'(lo32), 64'hFFFF_FFFF);

    // Start while busy is ignored
    launch(3'd1, 32'd3, 32'd5);
    @(negedge clk);
    op = 3'd1; srca = 32'd7; srcb = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("busy_ign_lo", 64'(lo32), 64'd15);
    check("busy_ign_hi", 64'(hi32), 64'd0);
    check("busy_ign_lo8", 64'(lo8), 64'd15);
    check("busy_ign_done", 64'(dn32), 64'd1);

    // flush beats a same-cycle MTHI; op 6 does nothing
    @(negedge clk);
    op = 3'd4; srca = 32'hA5A5_A5A5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    op = 3'd6; flush = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("flush_mthi", 64'(hi32), 64'd0);
    check("nop_busy", 64'(busy32), 64'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom_range(0, 7));
      srca  = pick();
      srcb  = pick();
      flush = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of an operation
    launch(3'd0, 32'h7, 32'h9);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy32", 64'(busy32), 64'd0);
    check("arst_hi32", 64'(hi32), 64'd0);
    check("arst_lo32", 64'(lo32), 64'd0);
    check("arst_busy8", 64'(busy8), 64'd0);
    cmp_en = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the execute-stage ALU and takes the same forwarded operands (post srca/srcb forwarding muxes).
- Raises busy so the hazard unit can stall decode/fetch while an operation is in flight.
- Supplies HI/LO to the execute-stage result path for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand, HI and LO width in bits; must be >= 4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 clears all state.
- start  in  1  request from execute stage; sampled only in IDLE.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op.
- srca  in  WIDTH  forwarded rs operand (multiplicand / dividend / MT source).
- srcb  in  WIDTH  forwarded rt operand (multiplier / divisor).
- flush  in  1  abort the in-flight operation (branch/exception squash).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  high while not IDLE; drives the stall.
- done  out  1  one-cycle pulse, registered, when HI/LO update from a MULT/DIV.
- divzero  out  1  registered alongside done; 1 if the completed DIV/DIVU had srcb==0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, done=0, divzero=0, counter=0, internal accumulators=0.
- States: IDLE, CALC, FIX.
- busy = (state != IDLE), combinational from state.
- IDLE, start=1, op=MTHI/MTLO: hi (or lo) <= srca at the same edge; stays IDLE; done stays 0.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU: latch operands, then go to CALC with counter=0.
  - Signed ops latch magnitudes and record the result signs: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- CALC: one radix-2 iteration per cycle, exactly WIDTH cycles; counter increments; go to FIX when counter==WIDTH-1.
  - Multiply: shift-add over a 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract.
- FIX: apply sign correction (two's-complement negate), write HI/LO, set done=1 for the following cycle, return to IDLE.
  - Multiply: {hi,lo} = full 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder.
- Latency: start sampled at edge E0 → HI/LO valid and done=1 after edge E(WIDTH+1). busy is high from after E0 until after E(WIDTH+1). For WIDTH=32: 33 busy cycles.
- Divide by zero: runs the full latency; result lo = all ones, hi = srca (original signed value); divzero=1 with done.
- Signed overflow case (DIV of most-negative / -1): lo = most-negative, hi = 0; no trap.
- start while busy: ignored; the hazard unit must hold the instruction in execute. No queuing.
- flush in CALC or FIX: return to IDLE next edge; HI/LO unchanged; done stays 0.
- flush and start in IDLE at the same edge: flush wins; nothing is started; MTHI/MTLO is not written.
- op 6/7 with start: ignored; no state change.
- reset deasserted mid-operation is not possible; reset asserted mid-operation aborts asynchronously to the reset values.
- done and divzero are 0 in every cycle other than the pulse.
- Arithmetic is unsigned on magnitudes, with no width truncation inside the accumulator (2*WIDTH+1 bits for the divide remainder path).

Decomposition:
- Shared package muldiv_pkg:
  - op encodings (MD_MULT..MD_MTLO).
  - state encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2).
- One sub-module: muldiv_core, the iteration datapath (accumulator, shift/add/subtract, counter compare).
- muldiv_unit itself holds the FSM, operand/sign latching, sign fixup, HI/LO and handshake outputs.

Test Plan:
- Reset and MTHI/MTLO:
  - Hold reset=0 → hi=lo=0, busy=0, done=0.
  - Then MTHI srca=0xDEADBEEF, next cycle MTLO srca=0x12345678 → hi=0xDEADBEEF, lo=0x12345678, busy never rises.
- MULT, WIDTH=32:
  - MULT 0xFFFFFFFF × 0x00000002 → after 33 busy cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFE, single done pulse.
  - MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV/DIVU:
  - DIV -7 / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU 100 / 7 → lo=14, hi=2.
  - DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- Divide by zero: DIVU 0x55 / 0 → lo=0xFFFFFFFF, hi=0x55, divzero=1 with done.
- Abort and contention:
  - Start MULT, assert flush on CALC cycle 10 → busy drops next cycle; hi/lo keep prior values; no done.
  - start with a new MULT while busy → ignored; the first result is unaffected.
- Parametrisation: rerun the MULT/DIV vectors at WIDTH=8.
  - Latency is 9 busy cycles.
  - MULT 0xFF × 0x02 → hi=0xFF, lo=0xFE.
